// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package mips_fetch_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ack port and decode valid/ready port of the fetch unit.
interface pc_fetch_unit_if;
  import mips_fetch_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] pc_addr;
  logic              inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc_addr,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc_addr,
    output imem_ack, imem_rdata, inst_ready
  );

endinterface

// File: rtl/pc_fetch_unit_queue.sv
// fetch_queue: shifting FIFO of {pc, inst}; the head always sits in slot 0 so the
// decode outputs come straight from flops.
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int               CW       = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  ent_q [DEPTH];
  fetch_entry_t  ent_d [DEPTH];
  logic [CW-1:0] count_q, count_d, cnt_pop;
  logic          empty_q, empty_d;
  logic          pop_ok, push_ok;

  always_comb begin
    ent_d   = ent_q;
    pop_ok  = pop && !empty_q;
    cnt_pop = count_q - CW'(pop_ok);
    push_ok = push && (cnt_pop != CW'(DEPTH));
    if (pop_ok) begin
      for (int i = 0; i < DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
    end
    if (push_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == cnt_pop) ent_d[i] = push_entry;
      end
    end
    count_d = flush ? '0 : cnt_pop + CW'(push_ok);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '{pc: RESET_PC, inst: '0};
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      ent_q   <= ent_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  assign head  = ent_q[0];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = empty_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC / fetch front end: request FSM, fetch queue and redirect handling.
// Define FETCH_MISALIGN_CHECK_EN to reject redirects whose target is not word aligned.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              branch_command,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              misalign_err,
  pc_fetch_unit_if.master   bus
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              imem_req_q, imem_req_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] target;
  logic              redirect, ack_acc, pop, push;
  logic [CW-1:0]     q_count, cnt_after;
  logic              q_full, q_empty;
  fetch_entry_t      q_head, push_entry;

  always_comb begin
    target = align_word(jump_addr);
`ifdef FETCH_MISALIGN_CHECK_EN
    redirect   = branch_command && (jump_addr[1:0] == 2'b00);
    misalign_d = branch_command && (jump_addr[1:0] != 2'b00);
`else
    redirect   = branch_command;
    misalign_d = 1'b0;
`endif
    // An ack only counts while a request is actually on the bus.
    ack_acc    = imem_req_q && bus.imem_ack;
    pop        = !q_empty && bus.inst_ready;
    push       = (state_q == REQ) && ack_acc && !redirect;
    push_entry = '{pc: imem_addr_q, inst: bus.imem_rdata};
    cnt_after  = q_count + CW'(push) - CW'(pop);

    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;

    case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d  = target;
          state_d     = REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = target;
        end else if (!q_full) begin
          state_d     = REQ;
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_pc_q;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (ack_acc) imem_addr_d = target;
          else         state_d     = DRAIN;
        end else if (ack_acc) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          // Keep one slot in reserve for the request about to be issued.
          if (cnt_after < CW'(QUEUE_DEPTH)) begin
            imem_addr_d = fetch_pc_q + PC_STEP;
          end else begin
            state_d    = IDLE;
            imem_req_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (redirect) fetch_pc_d = target;
        if (ack_acc) begin
          state_d     = REQ;
          imem_addr_d = redirect ? target : fetch_pc_q;
        end
      end
      default: begin
        state_d    = IDLE;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      misalign_q  <= misalign_d;
    end
  end

  fetch_queue #(
    .DEPTH    (QUEUE_DEPTH),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_valid = !q_empty;
  assign bus.inst       = q_head.inst;
  assign bus.pc_addr    = q_head.pc;
  assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: cycle table after reset, directed redirect/stall
// sequences, then randomized traffic against a stream-level reference model.
module tb_pc_fetch_unit;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  logic        clk;
  logic        rst_n;
  logic        branch_command;
  logic [31:0] jump_addr;
  logic        misalign_err;
  logic        mis2;

  int n_checks = 0;
  int n_err    = 0;

  pc_fetch_unit_if bus ();
  pc_fetch_unit_if bus2 ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_command (branch_command),
    .jump_addr      (jump_addr),
    .misalign_err   (misalign_err),
    .bus            (bus.master)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_command (1'b0),
    .jump_addr      (32'h0),
    .misalign_err   (mis2),
    .bus            (bus2.master)
  );

  assign bus2.imem_ack   = 1'b1;
  assign bus2.imem_rdata = memf(bus2.imem_addr);
  assign bus2.inst_ready = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs at a negedge and advance to the next negedge.
  task automatic cyc(input logic ack, input logic rdy, input logic br, input logic [31:0] ja);
    bus.imem_ack   = ack;
    bus.imem_rdata = ack ? memf(bus.imem_addr) : 32'hBAD0_0BAD;
    bus.inst_ready = rdy;
    branch_command = br;
    jump_addr      = ja;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req",    {31'b0, bus.imem_req},   32'h0);
    chk("rst_addr",   bus.imem_addr,           32'h0);
    chk("rst_valid",  {31'b0, bus.inst_valid}, 32'h0);
    chk("rst_inst",   bus.inst,                32'h0);
    chk("rst_pc",     bus.pc_addr,             32'h0);
    chk("rst_mis",    {31'b0, misalign_err},   32'h0);
    chk("rst_addr_w", bus2.imem_addr,          32'hFFFF_FFF8);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0;
    branch_command = 1'b0;
    jump_addr      = 32'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        ack;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_pc;
    logic [31:0] e_addr2;
    logic [31:0] e_pc2;
  } vec_t;

  vec_t tbl [5];

  logic [31:0] exp_pc, paddr, ja;
  logic        exp_mis, pend, flushed, ack, rdy, br, acc;
  int          delivered;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFF8, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h8, 1'b1, 32'h4, 32'h0000_0000, 32'hFFFF_FFFC};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 32'h0000_0004, 32'h0000_0000};

    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset release with acks every cycle; late ack at row 0 must be ignored.
    for (int i = 0; i < 5; i++) begin
      chk("tbl_req",   {31'b0, bus.imem_req},   {31'b0, tbl[i].e_req});
      chk("tbl_addr",  bus.imem_addr,           tbl[i].e_addr);
      chk("tbl_valid", {31'b0, bus.inst_valid}, {31'b0, tbl[i].e_vld});
      chk("tbl_addr_w", bus2.imem_addr,         tbl[i].e_addr2);
      if (tbl[i].e_vld) begin
        chk("tbl_pc",   bus.pc_addr,  tbl[i].e_pc);
        chk("tbl_inst", bus.inst,     memf(tbl[i].e_pc));
        chk("tbl_pc_w", bus2.pc_addr, tbl[i].e_pc2);
      end
      cyc(tbl[i].ack, tbl[i].rdy, 1'b0, 32'h0);
    end

    // Decode stalled: queue fills to depth and requests stop.
    for (int i = 5; i < 14; i++) begin
      chk("stall_req", {31'b0, bus.imem_req}, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
    end
    chk("stall_req_end", {31'b0, bus.imem_req},   32'h0);
    chk("stall_vld",     {31'b0, bus.inst_valid}, 32'h1);
    chk("stall_pc0",     bus.pc_addr,             32'h8);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_pc1",     bus.pc_addr,             32'hC);
    chk("stall_inst1",   bus.inst,                memf(32'hC));
    chk("stall_req1",    {31'b0, bus.imem_req},   32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_empty",   {31'b0, bus.inst_valid}, 32'h0);
    chk("stall_rereq",   {31'b0, bus.imem_req},   32'h1);
    chk("stall_readdr",  bus.imem_addr,           32'h10);

    // Reset with a request outstanding.
    do_reset();

    // Redirect while the request to 0x8 is still waiting for its ack.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_addr_pre", bus.imem_addr, 32'h8);
    cyc(1'b0, 1'b1, 1'b1, 32'h100);
    chk("drain_addr0", bus.imem_addr,           32'h8);
    chk("drain_vld0",  {31'b0, bus.inst_valid}, 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 32'h0);
    chk("drain_addr1", bus.imem_addr,           32'h8);
    chk("drain_req1",  {31'b0, bus.imem_req},   32'h1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_tgt",   bus.imem_addr,           32'h100);
    chk("drain_vld2",  {31'b0, bus.inst_valid}, 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("drain_pc",    bus.pc_addr,             32'h100);
    chk("drain_inst",  bus.inst,                memf(32'h100));

    // Redirect coincident with an ack while a word is buffered.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("coin_vld_pre", {31'b0, bus.inst_valid}, 32'h1);
    cyc(1'b1, 1'b0, 1'b1, 32'h200);
    chk("coin_vld",  {31'b0, bus.inst_valid}, 32'h0);
    chk("coin_addr", bus.imem_addr,           32'h200);
    chk("coin_req",  {31'b0, bus.imem_req},   32'h1);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("coin_pc",   bus.pc_addr,             32'h200);
    chk("coin_vld2", {31'b0, bus.inst_valid}, 32'h1);

    // Misaligned redirect target.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_pulse", {31'b0, misalign_err}, 32'h1);
    chk("mis_addr",  bus.imem_addr,         32'hC);
    chk("mis_pc",    bus.pc_addr,           32'h8);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_clear", {31'b0, misalign_err}, 32'h0);
    chk("mis_pc2",   bus.pc_addr,           32'hC);
`else
    chk("mis_none",  {31'b0, misalign_err}, 32'h0);
    chk("mis_addr",  bus.imem_addr,         32'h100);
    cyc(1'b1, 1'b1, 1'b0, 32'h0);
    chk("mis_pc",    bus.pc_addr,           32'h100);
`endif

    // Redirect with nothing outstanding.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 32'h300);
    chk("idle_req",  {31'b0, bus.imem_req}, 32'h1);
    chk("idle_addr", bus.imem_addr,         32'h300);

    // Randomized traffic against the stream model.
    do_reset();
    exp_pc    = 32'h0;
    exp_mis   = 1'b0;
    pend      = 1'b0;
    flushed   = 1'b0;
    paddr     = 32'h0;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pend) begin
        chk("rnd_hold_req",  {31'b0, bus.imem_req}, 32'h1);
        chk("rnd_hold_addr", bus.imem_addr,         paddr);
      end
      if (flushed) chk("rnd_flush", {31'b0, bus.inst_valid}, 32'h0);
      chk("rnd_mis", {31'b0, misalign_err}, {31'b0, exp_mis});

      ack = ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 19) == 0);
      ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;

      if (bus.inst_valid && rdy) begin
        chk("rnd_pc",   bus.pc_addr, exp_pc);
        chk("rnd_inst", bus.inst,    memf(bus.pc_addr));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      acc     = br && (ja[1:0] == 2'b00);
      exp_mis = br && !acc;
`else
      acc     = br;
      exp_mis = 1'b0;
`endif
      if (acc) exp_pc = {ja[31:2], 2'b00};
      flushed = acc;
      pend    = bus.imem_req && !ack;
      paddr   = bus.imem_addr;
      cyc(ack, rdy, br, ja);
    end
    chk("rnd_progress", {31'b0, (delivered > 200)}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
